// File: rtl/piradip_latency_matcher_pkg.sv
// Shared types and helpers for the sideband latency matcher.
// Holds the control FSM encoding and the latency clamp used on configuration.
package piradip_latency_matcher_pkg;

   typedef enum logic {
      LM_RUN,
      LM_FLUSH
   } latmatch_state_t;

   function automatic logic [31:0] clamp_latency(input logic [31:0] req, input logic [31:0] max_lat);
      return (req > max_lat) ? max_lat : req;
   endfunction

endpackage

// File: rtl/piradip_latency_matcher_lane.sv
// One lane of the sideband delay line: a MAX_LATENCY-deep shift of {valid, oob}
// with a runtime-selected output tap and a zero-latency combinational bypass.
module piradip_latency_matcher_lane
   import piradip_latency_matcher_pkg::*;
#(
   parameter int MAX_LATENCY = 16,
   parameter int OOB_W       = 1,
   parameter int LAT_W       = $clog2(MAX_LATENCY + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [LAT_W-1:0] cur_latency,
   input  logic             clear_valid,
   input  logic             suppress,
   input  logic             in_valid,
   input  logic [OOB_W-1:0] in_oob,
   output logic             out_valid,
   output logic [OOB_W-1:0] out_oob,
   output logic             busy
);

   logic [MAX_LATENCY-1:0] valid_sr;
   logic [OOB_W-1:0]       oob_sr [MAX_LATENCY];
   logic                   tap_valid;
   logic [OOB_W-1:0]       tap_oob;
   logic                   stage_busy;

   // Stage 0 always captures the input; a latency change wipes every older valid.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_sr <= '0;
         for (int i = 0; i < MAX_LATENCY; i++) begin
            oob_sr[i] <= '0;
         end
      end else begin
         valid_sr[0] <= in_valid;
         oob_sr[0]   <= in_oob;
         for (int i = MAX_LATENCY - 1; i > 0; i--) begin
            valid_sr[i] <= clear_valid ? 1'b0 : valid_sr[i-1];
            oob_sr[i]   <= oob_sr[i-1];
         end
      end
   end

   always_comb begin
      tap_valid  = 1'b0;
      tap_oob    = '0;
      stage_busy = 1'b0;
      for (int i = 0; i < MAX_LATENCY; i++) begin
         if (cur_latency == LAT_W'(i + 1)) begin
            tap_valid = valid_sr[i];
            tap_oob   = oob_sr[i];
         end
         if (valid_sr[i] && (LAT_W'(i) < cur_latency)) begin
            stage_busy = 1'b1;
         end
      end
   end

   always_comb begin
      busy = stage_busy;
      if (cur_latency == '0) begin
         out_valid = in_valid;
         out_oob   = in_oob;
      end else begin
         out_valid = tap_valid & ~suppress;
         out_oob   = tap_oob;
      end
   end

endmodule

// File: rtl/piradip_latency_matcher.sv
// Multi-lane sideband latency matcher: delays valid/oob by a software-selected
// latency and concatenates them with the already-delayed in-band data.
module piradip_latency_matcher
   import piradip_latency_matcher_pkg::*;
#(
   parameter int NUM_CHANNELS      = 2,
   parameter int IN_BAND_WIDTH     = 32,
   parameter int OUT_OF_BAND_WIDTH = 1,
   parameter int MAX_LATENCY       = 16,
   parameter int LAT_W             = $clog2(MAX_LATENCY + 1)
) (
   input  logic                                                   clk,
   input  logic                                                   resetn,
   input  logic [LAT_W-1:0]                                       cfg_latency,
   input  logic                                                   cfg_load,
   output logic [LAT_W-1:0]                                       cur_latency,
   output logic                                                   cfg_err,
   output logic                                                   flushing,
   output logic                                                   busy,
   input  logic [NUM_CHANNELS-1:0]                                in_valid,
   input  logic [NUM_CHANNELS*OUT_OF_BAND_WIDTH-1:0]              out_of_band,
   input  logic [NUM_CHANNELS*IN_BAND_WIDTH-1:0]                  in_band,
   output logic [NUM_CHANNELS-1:0]                                out_valid,
   output logic [NUM_CHANNELS*(IN_BAND_WIDTH+OUT_OF_BAND_WIDTH)-1:0] out_data
);

   localparam int OOB_SW = (OUT_OF_BAND_WIDTH > 0) ? OUT_OF_BAND_WIDTH : 1;
   localparam int LANE_W = IN_BAND_WIDTH + OUT_OF_BAND_WIDTH;

   latmatch_state_t         state, state_next;
   logic [LAT_W-1:0]        flush_cnt;
   logic [LAT_W-1:0]        req_latency;
   logic                    req_clamped;
   logic                    apply_cfg;
   logic [NUM_CHANNELS-1:0] lane_busy;

   // A load that resolves to the latency already in force is deliberately ignored.
   always_comb begin
      req_latency = LAT_W'(clamp_latency(32'(cfg_latency), 32'(MAX_LATENCY)));
      req_clamped = 32'(cfg_latency) > 32'(MAX_LATENCY);
      apply_cfg   = cfg_load && (req_latency != cur_latency);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= LM_RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (apply_cfg) begin
         state_next = (req_latency == '0) ? LM_RUN : LM_FLUSH;
      end else if ((state == LM_FLUSH) && (flush_cnt <= LAT_W'(1))) begin
         state_next = LM_RUN;
      end
   end

   always_comb begin
      flushing = (state == LM_FLUSH);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cur_latency <= LAT_W'(1);
         flush_cnt   <= '0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err <= cfg_err | (cfg_load & req_clamped);
         if (apply_cfg) begin
            cur_latency <= req_latency;
            flush_cnt   <= req_latency;
         end else if ((state == LM_FLUSH) && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - LAT_W'(1);
         end
      end
   end

   for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
      logic [OOB_SW-1:0] lane_oob_in;
      logic [OOB_SW-1:0] lane_oob_out;

      if (OUT_OF_BAND_WIDTH > 0) begin : g_oob
         assign lane_oob_in = out_of_band[k*OUT_OF_BAND_WIDTH +: OUT_OF_BAND_WIDTH];
         assign out_data[k*LANE_W +: LANE_W] = {lane_oob_out, in_band[k*IN_BAND_WIDTH +: IN_BAND_WIDTH]};
      end else begin : g_no_oob
         assign lane_oob_in = '0;
         assign out_data[k*LANE_W +: LANE_W] = in_band[k*IN_BAND_WIDTH +: IN_BAND_WIDTH];
      end

      piradip_latency_matcher_lane #(
         .MAX_LATENCY (MAX_LATENCY),
         .OOB_W       (OOB_SW),
         .LAT_W       (LAT_W)
      ) u_lane (
         .clk         (clk),
         .resetn      (resetn),
         .cur_latency (cur_latency),
         .clear_valid (apply_cfg),
         .suppress    (flushing),
         .in_valid    (in_valid[k]),
         .in_oob      (lane_oob_in),
         .out_valid   (out_valid[k]),
         .out_oob     (lane_oob_out),
         .busy        (lane_busy[k])
      );
   end

   assign busy = |lane_busy;

endmodule
